// File: rtl/conv_sched_pkg.sv
// Shared constants and state encoding for the convolution row scheduler.
package conv_sched_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PERF_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_FILL    = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/sched_cycle_counter.sv
// Loadable down-counter with a zero flag; times the COMPUTE phase.
module sched_cycle_counter
  import conv_sched_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/conv_row_scheduler.sv
// Layer sequencer: weight load once, then FILL/COMPUTE/DRAIN per output row.
// Optional build macro SCHED_PERF_CNT_EN adds busy_cycles/stall_cycles counters.
module conv_row_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE    = 9,
  parameter int unsigned DIM_DATA_SIZE = 8,
  parameter int unsigned ADDR_WIDTH    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIM_DATA_SIZE-1:0] weight_size,
  input  logic [DIM_DATA_SIZE-1:0] image_height,
  input  logic [DIM_DATA_SIZE-1:0] image_width,
  input  logic [ADDR_WIDTH-1:0]    image_base_address,
  output logic                     weight_load_start,
  input  logic                     weight_load_done,
  output logic                     fill_start,
  output logic [ADDR_WIDTH-1:0]    fill_initial_address,
  input  logic                     fill_completed,
  output logic                     array_enable,
  output logic                     drain_start,
  input  logic                     drain_done,
  output logic                     busy,
  output logic                     done,
  output logic                     config_error,
`ifdef SCHED_PERF_CNT_EN
  output logic [PERF_W-1:0]        busy_cycles,
  output logic [PERF_W-1:0]        stall_cycles,
`endif
  output logic [STATE_W-1:0]       state
);

  localparam int unsigned KK_W = 2 * DIM_DATA_SIZE;

  state_t                   cur_state;
  state_t                   next_state;
  logic [DIM_DATA_SIZE-1:0] img_w;
  logic [DIM_DATA_SIZE-1:0] out_h;
  logic [DIM_DATA_SIZE-1:0] row;
  logic [ADDR_WIDTH-1:0]    row_addr;
  logic [CNT_W-1:0]         compute_len;

  logic [KK_W-1:0]          kk_c;
  logic [DIM_DATA_SIZE-1:0] out_w_c;
  logic [CNT_W-1:0]         len_c;
  logic                     cfg_ok_c;
  logic                     accept_c;
  logic                     last_row_c;
  logic [ADDR_WIDTH-1:0]    addr_step_c;
  logic                     cnt_load_c;
  logic                     cnt_dec_c;
  logic                     cnt_zero_c;

  assign state = cur_state;

  // Configuration checks and derived values from the live inputs.
  always_comb begin
    kk_c        = KK_W'(weight_size) * KK_W'(weight_size);
    out_w_c     = image_width - weight_size + DIM_DATA_SIZE'(1);
    len_c       = CNT_W'(kk_c) + CNT_W'(out_w_c) + CNT_W'(ARRAY_SIZE - 1);
    cfg_ok_c    = (weight_size != '0) && (weight_size <= image_height) &&
                  (weight_size <= image_width) && (32'(kk_c) <= 32'(ARRAY_SIZE));
    accept_c    = (cur_state == S_IDLE) && start && !abort;
    last_row_c  = (row == out_h - DIM_DATA_SIZE'(1));
    addr_step_c = row_addr + ADDR_WIDTH'(img_w);
  end

  // COMPUTE length timer, loaded with L-1 so the state lasts exactly L cycles.
  sched_cycle_counter #(.WIDTH(CNT_W)) u_len_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_c),
    .dec        (cnt_dec_c),
    .load_value (compute_len - CNT_W'(1)),
    .zero_c     (cnt_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; a done input is ignored while its own start pulse is high.
  always_comb begin
    next_state = cur_state;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE:    if (start) next_state = cfg_ok_c ? S_LOAD_W : S_ERR;
        S_LOAD_W:  if (!weight_load_start && weight_load_done) next_state = S_FILL;
        S_FILL: begin
          if (!fill_start && fill_completed) begin
            next_state = S_COMPUTE;
            cnt_load_c = 1'b1;
          end
        end
        S_COMPUTE: begin
          if (cnt_zero_c) next_state = S_DRAIN;
          else            cnt_dec_c  = 1'b1;
        end
        S_DRAIN: begin
          if (!drain_start && drain_done) next_state = last_row_c ? S_DONE : S_FILL;
        end
        S_DONE:    next_state = S_IDLE;
        S_ERR:     next_state = S_IDLE;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // Registered control outputs, aligned with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_load_start <= 1'b0;
      fill_start        <= 1'b0;
      drain_start       <= 1'b0;
      array_enable      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      weight_load_start <= (next_state == S_LOAD_W) && (cur_state != S_LOAD_W);
      fill_start        <= (next_state == S_FILL)   && (cur_state != S_FILL);
      drain_start       <= (next_state == S_DRAIN)  && (cur_state != S_DRAIN);
      array_enable      <= (next_state == S_COMPUTE);
      busy              <= (next_state != S_IDLE);
      done              <= (next_state == S_DONE) || (next_state == S_ERR);
    end
  end

  // Latched layer configuration, row/address accumulator and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_w                <= '0;
      out_h                <= '0;
      compute_len          <= '0;
      row                  <= '0;
      row_addr             <= '0;
      config_error         <= 1'b0;
      fill_initial_address <= '0;
    end else begin
      if (accept_c) begin
        img_w        <= image_width;
        out_h        <= image_height - weight_size + DIM_DATA_SIZE'(1);
        compute_len  <= len_c;
        row          <= '0;
        row_addr     <= image_base_address;
        config_error <= !cfg_ok_c;
      end
      if ((cur_state == S_DRAIN) && (next_state == S_FILL)) begin
        row      <= row + DIM_DATA_SIZE'(1);
        row_addr <= addr_step_c;
      end
      if ((next_state == S_FILL) && (cur_state != S_FILL)) begin
        fill_initial_address <= (cur_state == S_DRAIN) ? addr_step_c : row_addr;
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic stall_c;

  // Waiting cycles in handshake states, excluding each state's pulse cycle.
  always_comb begin
    stall_c = ((cur_state == S_LOAD_W) && !weight_load_start) ||
              ((cur_state == S_FILL)   && !fill_start) ||
              ((cur_state == S_DRAIN)  && !drain_start);
  end

  // Saturating performance counters, cleared by an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else if (accept_c) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && (busy_cycles != '1))     busy_cycles  <= busy_cycles + PERF_W'(1);
      if (stall_c && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Self-checking bench for conv_row_scheduler with fill-address / burst-length scoreboard.
`timescale 1ns/1ps
module tb_conv_row_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 20;
  localparam int unsigned AS = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] weight_size = '0;
  logic [DW-1:0] image_height = '0;
  logic [DW-1:0] image_width = '0;
  logic [AW-1:0] image_base_address = '0;
  logic          weight_load_start;
  logic          weight_load_done;
  logic          fill_start;
  logic [AW-1:0] fill_initial_address;
  logic          fill_completed;
  logic          array_enable;
  logic          drain_start;
  logic          drain_done;
  logic          busy;
  logic          done;
  logic          config_error;
  logic [2:0]    state;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]   busy_cycles;
  logic [31:0]   stall_cycles;
`endif

  conv_row_scheduler #(.ARRAY_SIZE(AS), .DIM_DATA_SIZE(DW), .ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .weight_size          (weight_size),
    .image_height         (image_height),
    .image_width          (image_width),
    .image_base_address   (image_base_address),
    .weight_load_start    (weight_load_start),
    .weight_load_done     (weight_load_done),
    .fill_start           (fill_start),
    .fill_initial_address (fill_initial_address),
    .fill_completed       (fill_completed),
    .array_enable         (array_enable),
    .drain_start          (drain_start),
    .drain_done           (drain_done),
    .busy                 (busy),
    .done                 (done),
    .config_error         (config_error),
`ifdef SCHED_PERF_CNT_EN
    .busy_cycles          (busy_cycles),
    .stall_cycles         (stall_cycles),
`endif
    .state                (state)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] addr_q[$];
  int            len_q[$];
  int            burst = 0;
  int            fill_cnt = 0;
  int            wls_cnt = 0;
  int            done_cnt = 0;
  int            busy_cnt = 0;
  logic [AW-1:0] last_fill = '0;
  int            resp_delay = 2;
  bit            early_ack = 1'b0;

  // Weight loader model: done arrives resp_delay cycles after the start pulse.
  initial begin : wl_resp
    weight_load_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (weight_load_start) begin
        if (early_ack) weight_load_done = 1'b1;
        @(posedge clk); #1 weight_load_done = 1'b0;
        repeat (resp_delay - 1) @(posedge clk);
        #1 weight_load_done = 1'b1;
        @(posedge clk); #1 weight_load_done = 1'b0;
      end
    end
  end

  // Fill controller model.
  initial begin : fill_resp
    fill_completed = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fill_start) begin
        if (early_ack) fill_completed = 1'b1;
        @(posedge clk); #1 fill_completed = 1'b0;
        repeat (resp_delay - 1) @(posedge clk);
        #1 fill_completed = 1'b1;
        @(posedge clk); #1 fill_completed = 1'b0;
      end
    end
  end

  // Output drain model.
  initial begin : drain_resp
    drain_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (drain_start) begin
        if (early_ack) drain_done = 1'b1;
        @(posedge clk); #1 drain_done = 1'b0;
        repeat (resp_delay - 1) @(posedge clk);
        #1 drain_done = 1'b1;
        @(posedge clk); #1 drain_done = 1'b0;
      end
    end
  end

  // Advance one cycle and compare DUT outputs against the scoreboard.
  task automatic step();
    bit            drop;
    logic [AW-1:0] exp_a;
    int            exp_l;
    drop = abort || !reset;
    @(negedge clk);
    if (drop || !reset) begin
      burst = 0;
      return;
    end
    if (weight_load_start) wls_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (fill_start) begin
      fill_cnt++;
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL fill_addr: unexpected fill, got %h", fill_initial_address);
      end else begin
        exp_a = addr_q.pop_front();
        last_fill = exp_a;
        if (fill_initial_address !== exp_a) begin
          errors++;
          $display("FAIL fill_addr: got %h expected %h", fill_initial_address, exp_a);
        end
      end
    end else if (state == 3'd2) begin
      checks++;
      if (fill_initial_address !== last_fill) begin
        errors++;
        $display("FAIL fill_hold: got %h expected %h", fill_initial_address, last_fill);
      end
    end
    if (array_enable === 1'b1) begin
      burst++;
    end else if (burst != 0) begin
      checks++;
      if (len_q.size() == 0) begin
        errors++;
        $display("FAIL burst_len: unexpected burst of %0d", burst);
      end else begin
        exp_l = len_q.pop_front();
        if (burst != exp_l) begin
          errors++;
          $display("FAIL burst_len: got %0d expected %0d", burst, exp_l);
        end
      end
      burst = 0;
    end
  endtask

  // Drive a one-cycle start; push expected fills and burst lengths if it should be accepted.
  task automatic pulse_start(input int k, input int h, input int w,
                             input logic [AW-1:0] base, input bit expect_accept);
    weight_size        = DW'(k);
    image_height       = DW'(h);
    image_width        = DW'(w);
    image_base_address = base;
    if (expect_accept && k != 0 && k <= h && k <= w && k * k <= int'(AS)) begin
      for (int r = 0; r <= h - k; r++) begin
        addr_q.push_back(AW'(base + AW'(r * w)));
        len_q.push_back(k * k + (w - k + 1) + int'(AS) - 1);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < max) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int fills, input int max);
    int n;
    n = 0;
    while (!(state === s && fill_cnt >= fills) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL wait_state: got %0d expected %0d", state, s);
    end
  endtask

  task automatic clear_counts();
    fill_cnt = 0; wls_cnt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, busy, done, config_error, array_enable, weight_load_start, fill_start, drain_start} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {state, busy, done, config_error, array_enable,
                                                      weight_load_start, fill_start, drain_start});
    end
    checks++;
    if (fill_initial_address !== 20'd0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0", fill_initial_address);
    end
    reset = 1'b1;
    step();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: state %0d busy %b expected 0 0", state, busy);
    end
  endtask

  task automatic test_basic_run();
    clear_counts();
    pulse_start(3, 5, 5, 20'h0, 1'b1);
    wait_done(500);
    step();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: state %0d busy %b done %b expected 0 0 0", state, busy, done);
    end
    checks++;
    if (done_cnt != 1 || wls_cnt != 1 || fill_cnt != 3) begin
      errors++;
      $display("FAIL basic_counts: done %0d wls %0d fills %0d expected 1 1 3", done_cnt, wls_cnt, fill_cnt);
    end
    checks++;
    if (addr_q.size() != 0 || len_q.size() != 0) begin
      errors++;
      $display("FAIL basic_sb: left addr %0d len %0d expected 0 0", addr_q.size(), len_q.size());
    end
  endtask

  task automatic test_config_error();
    clear_counts();
    pulse_start(4, 5, 5, 20'h0, 1'b1);
    checks++;
    if (state !== 3'd6 || done !== 1'b1) begin
      errors++;
      $display("FAIL err_state: state %0d done %b expected 6 1", state, done);
    end
    step();
    checks++;
    if (state !== 3'd0 || config_error !== 1'b1 || done !== 1'b0 || wls_cnt != 0) begin
      errors++;
      $display("FAIL err_after: state %0d cfg_err %b done %b wls %0d expected 0 1 0 0",
               state, config_error, done, wls_cnt);
    end
    pulse_start(3, 3, 3, 20'h100, 1'b1);
    checks++;
    if (config_error !== 1'b0 || state !== 3'd1) begin
      errors++;
      $display("FAIL err_clear: cfg_err %b state %0d expected 0 1", config_error, state);
    end
    wait_done(300);
    step();
    checks++;
    if (done_cnt != 2 || fill_cnt != 1) begin
      errors++;
      $display("FAIL err_recover: done %0d fills %0d expected 2 1", done_cnt, fill_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    clear_counts();
    pulse_start(3, 5, 5, 20'h40, 1'b1);
    wait_state(3'd3, 1, 200);
    pulse_start(1, 7, 7, 20'h999, 1'b0);
    wait_done(600);
    step();
    checks++;
    if (done_cnt != 1 || fill_cnt != 3 || addr_q.size() != 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL busy_start: done %0d fills %0d left %0d state %0d expected 1 3 0 0",
               done_cnt, fill_cnt, addr_q.size(), state);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    pulse_start(3, 5, 5, 20'h200, 1'b1);
    wait_state(3'd3, 1, 200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (state !== 3'd0 || array_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || config_error !== 1'b0) begin
      errors++;
      $display("FAIL abort: state %0d en %b busy %b done %b cfg %b expected 0 0 0 0 0",
               state, array_enable, busy, done, config_error);
    end
    repeat (10) step();
    checks++;
    if (done_cnt != 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL abort_quiet: done %0d state %0d expected 0 0", done_cnt, state);
    end
    addr_q.delete();
    len_q.delete();
  endtask

  task automatic test_reset_mid_run();
    clear_counts();
    pulse_start(3, 5, 5, 20'h300, 1'b1);
    wait_state(3'd3, 2, 400);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (array_enable !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en %b state %0d busy %b expected 0 0 0", array_enable, state, busy);
    end
    step();
    addr_q.delete();
    len_q.delete();
    clear_counts();
    reset = 1'b1;
    pulse_start(3, 5, 5, 20'h300, 1'b1);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL restart: state %0d expected 1", state);
    end
    wait_done(600);
    step();
    checks++;
    if (fill_cnt != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_run: fills %0d done %0d expected 3 1", fill_cnt, done_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    clear_counts();
    pulse_start(3, 5, 5, 20'hFFFFE, 1'b1);
    wait_done(600);
    step();
    checks++;
    if (fill_cnt != 3 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_run: fills %0d left %0d expected 3 0", fill_cnt, addr_q.size());
    end
  endtask

  task automatic test_early_ack();
    int n;
    clear_counts();
    early_ack = 1'b1;
    pulse_start(1, 1, 1, 20'h55, 1'b1);
    step();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL early_wl: state %0d expected 1", state);
    end
    n = 0;
    while (fill_start !== 1'b1 && n < 50) begin step(); n++; end
    step();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL early_fill: state %0d expected 2", state);
    end
    n = 0;
    while (drain_start !== 1'b1 && n < 50) begin step(); n++; end
    step();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL early_drain: state %0d expected 4", state);
    end
    wait_done(100);
    early_ack = 1'b0;
    step();
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_perf();
    clear_counts();
    resp_delay = 4;
    pulse_start(3, 5, 5, 20'h0, 1'b1);
    wait_done(800);
    step();
    step();
    checks++;
    if (stall_cycles !== 32'd28) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected 28", stall_cycles);
    end
    checks++;
    if (busy_cycles !== 32'(busy_cnt)) begin
      errors++;
      $display("FAIL perf_busy: got %0d expected %0d", busy_cycles, busy_cnt);
    end
    resp_delay = 2;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_config_error();
    test_start_while_busy();
    test_abort();
    test_reset_mid_run();
    test_addr_wrap();
    test_early_ack();
`ifdef SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
